multi_dataflow_tcdm_load_arbiter: RTL and testbench

//  Parametrised N-channel load arbiter for the multi_dataflow streamer.
//  It lets NB_CH source-side TCDM load channels share one TCDM master port:

---
 rtl/multi_dataflow_tcdm_load_arbiter.sv | 151 +++++++++++++++
 tb/tb_multi_dataflow_tcdm_load_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_dataflow_tcdm_load_arbiter.sv
// Round-robin load arbiter sharing one TCDM master port between NB_CH source channels,
// with address lock under stall and in-order response routing through a channel-ID FIFO.
module multi_dataflow_tcdm_load_arbiter #(
    parameter int unsigned NB_CH       = 3,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   clear_i,
    input  logic [NB_CH-1:0]                       ch_en_i,
    input  logic [NB_CH-1:0]                       ch_req_i,
    input  logic [NB_CH*ADDR_WIDTH-1:0]            ch_add_i,
    output logic [NB_CH-1:0]                       ch_gnt_o,
    output logic [NB_CH*DATA_WIDTH-1:0]            ch_r_data_o,
    output logic [NB_CH-1:0]                       ch_r_valid_o,
    output logic                                   tcdm_req_o,
    output logic [ADDR_WIDTH-1:0]                  tcdm_add_o,
    output logic                                   tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0]                tcdm_be_o,
    input  logic                                   tcdm_gnt_i,
    input  logic [DATA_WIDTH-1:0]                  tcdm_r_data_i,
    input  logic                                   tcdm_r_valid_i,
    output logic [$clog2(OUTSTANDING+1)-1:0]       inflight_o,
    output logic                                   busy_o,
    output logic                                   err_o
);

    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
    localparam int unsigned ID_W  = $clog2(NB_CH);
    localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [ID_W-1:0]  lock_id_q, lock_id_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             err_q, err_d;
    logic [ID_W-1:0]  id_fifo_q [OUTSTANDING];
    logic [ID_W-1:0]  id_fifo_d [OUTSTANDING];

    logic [NB_CH-1:0] elig;
    logic [ID_W-1:0]  scan_sel;
    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  head;
    logic             can_issue;
    logic             fifo_empty;
    logic             req_c;
    logic             hs_c;
    logic             pop_c;
    int               idx;

    // Round-robin scan; walking backwards lets the first channel in scan order win.
    always_comb begin
        elig     = ch_req_i & ch_en_i;
        scan_sel = '0;
        idx      = 0;
        for (int i = int'(NB_CH) - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= int'(NB_CH)) idx = idx - int'(NB_CH);
            if (elig[idx]) scan_sel = ID_W'(idx);
        end
        sel = lock_q ? lock_id_q : scan_sel;
    end

    assign can_issue  = inflight_q < CNT_W'(OUTSTANDING);
    assign fifo_empty = (inflight_q == '0);
    assign head       = id_fifo_q[rd_ptr_q];
    assign req_c      = rst_ni & can_issue & (lock_q | (|elig));
    assign hs_c       = req_c & tcdm_gnt_i;
    assign pop_c      = rst_ni & tcdm_r_valid_i & ~fifo_empty;

    assign tcdm_req_o   = req_c;
    assign tcdm_add_o   = req_c ? ch_add_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign tcdm_wen_o   = 1'b1;
    assign tcdm_be_o    = '1;
    assign ch_gnt_o     = hs_c ? (NB_CH'(1) << sel) : '0;
    assign ch_r_valid_o = pop_c ? (NB_CH'(1) << head) : '0;
    assign ch_r_data_o  = rst_ni ? {NB_CH{tcdm_r_data_i}} : '0;
    assign inflight_o   = rst_ni ? inflight_q : '0;
    assign busy_o       = rst_ni & ((inflight_q != '0) | lock_q);
    assign err_o        = rst_ni & err_q;

    // Next-state: handshake/stall, FIFO push/pop, occupancy and clear.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_id_d  = lock_id_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q;
        err_d      = err_q;
        id_fifo_d  = id_fifo_q;

        if (hs_c) begin
            id_fifo_d[wr_ptr_q] = sel;
            wr_ptr_d = (wr_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
            rr_ptr_d = (sel == ID_W'(NB_CH - 1)) ? '0 : sel + 1'b1;
            lock_d   = 1'b0;
        end else if (req_c) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end

        if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (tcdm_r_valid_i && fifo_empty) err_d = 1'b1;

        if (hs_c && !pop_c) inflight_d = inflight_q + 1'b1;
        else if (!hs_c && pop_c) inflight_d = inflight_q - 1'b1;

        if (clear_i) begin
            rr_ptr_d   = '0;
            lock_d     = 1'b0;
            lock_id_d  = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = '0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // ID storage needs no reset: entries are only read when occupancy is non-zero.
    always_ff @(posedge clk_i) begin
        id_fifo_q <= id_fifo_d;
    end

endmodule

// File: tb/tb_multi_dataflow_tcdm_load_arbiter.sv
// Directed bench for the TCDM load arbiter: expected grant IDs are queued on issue
// and popped to check response routing.
module tb_multi_dataflow_tcdm_load_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic [2:0]  ch_en_i;
    logic [2:0]  ch_req_i;
    logic [95:0] ch_add_i;
    logic [2:0]  ch_gnt_o;
    logic [95:0] ch_r_data_o;
    logic [2:0]  ch_r_valid_o;
    logic        tcdm_req_o;
    logic [31:0] tcdm_add_o;
    logic        tcdm_wen_o;
    logic [3:0]  tcdm_be_o;
    logic        tcdm_gnt_i;
    logic [31:0] tcdm_r_data_i;
    logic        tcdm_r_valid_i;
    logic [2:0]  inflight_o;
    logic        busy_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] addr(input int ch);
        return 32'h0000_1000 + 32'(ch) * 32'h40;
    endfunction

    function automatic logic [2:0] oh(input int ch);
        return 3'(1 << ch);
    endfunction

    assign ch_add_i = {addr(2), addr(1), addr(0)};

    multi_dataflow_tcdm_load_arbiter #(
        .NB_CH(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .OUTSTANDING(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .ch_en_i(ch_en_i), .ch_req_i(ch_req_i), .ch_add_i(ch_add_i),
        .ch_gnt_o(ch_gnt_o), .ch_r_data_o(ch_r_data_o), .ch_r_valid_o(ch_r_valid_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
        .tcdm_be_o(tcdm_be_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_r_data_i(tcdm_r_data_i),
        .tcdm_r_valid_i(tcdm_r_valid_i), .inflight_o(inflight_o), .busy_o(busy_o),
        .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] en, input logic gnt,
                         input logic rv, input logic [31:0] d);
        ch_req_i       = req;
        ch_en_i        = en;
        tcdm_gnt_i     = gnt;
        tcdm_r_valid_i = rv;
        tcdm_r_data_i  = d;
        #2;
    endtask

    task automatic exp_grant(input int ch);
        chk("tcdm_req", 128'(tcdm_req_o), 128'(1));
        chk("ch_gnt", 128'(ch_gnt_o), 128'(oh(ch)));
        chk("tcdm_add", 128'(tcdm_add_o), 128'(addr(ch)));
        exp_q.push_back(ch);
    endtask

    task automatic exp_resp(input logic [31:0] d);
        int e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 128'(0), 128'(1));
        end else begin
            e = exp_q.pop_front();
            chk("ch_r_valid", 128'(ch_r_valid_o), 128'(oh(e)));
            chk("ch_r_data", 128'(ch_r_data_o), 128'({d, d, d}));
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        clear_i = 1'b0;
        drive(3'b111, 3'b111, 1'b1, 1'b1, 32'hDEAD_BEEF);
        tick();
        tick();
        // Reset: outputs quiet except tied ones
        chk("rst_req", 128'(tcdm_req_o), 128'(0));
        chk("rst_gnt", 128'(ch_gnt_o), 128'(0));
        chk("rst_rvalid", 128'(ch_r_valid_o), 128'(0));
        chk("rst_rdata", 128'(ch_r_data_o), 128'(0));
        chk("rst_add", 128'(tcdm_add_o), 128'(0));
        chk("rst_inflight", 128'(inflight_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));
        chk("rst_wen", 128'(tcdm_wen_o), 128'(1));
        chk("rst_be", 128'(tcdm_be_o), 128'(4'hF));
        rst_ni = 1'b1;

        // Test 1: round robin with single-cycle responses
        for (int i = 0; i < 6; i++) begin
            drive(3'b111, 3'b111, 1'b1, (i > 0), 32'hD000_0000 + 32'(i));
            if (i > 0) exp_resp(32'hD000_0000 + 32'(i));
            exp_grant(i % 3);
            chk("t1_inflight", 128'(inflight_o), 128'((i > 0) ? 1 : 0));
            tick();
        end
        drive(3'b000, 3'b111, 1'b1, 1'b1, 32'hD000_0006);
        exp_resp(32'hD000_0006);
        tick();
        drive(3'b000, 3'b111, 1'b1, 1'b0, 32'h0);
        chk("t1_drain", 128'(inflight_o), 128'(0));

        // Test 2: stall locks ch1 address; ch0 arrives during stall
        tick();
        drive(3'b010, 3'b111, 1'b0, 1'b0, 32'h0);
        chk("t2_req", 128'(tcdm_req_o), 128'(1));
        chk("t2_add0", 128'(tcdm_add_o), 128'(addr(1)));
        chk("t2_nognt", 128'(ch_gnt_o), 128'(0));
        tick();
        drive(3'b011, 3'b111, 1'b0, 1'b0, 32'h0);
        chk("t2_add1", 128'(tcdm_add_o), 128'(addr(1)));
        chk("t2_busy", 128'(busy_o), 128'(1));
        tick();
        drive(3'b011, 3'b111, 1'b0, 1'b0, 32'h0);
        chk("t2_add2", 128'(tcdm_add_o), 128'(addr(1)));
        tick();
        drive(3'b011, 3'b111, 1'b1, 1'b0, 32'h0);
        exp_grant(1);
        tick();
        drive(3'b001, 3'b111, 1'b1, 1'b0, 32'h0);
        exp_grant(0);
        tick();
        drive(3'b000, 3'b111, 1'b1, 1'b1, 32'hA000_0001);
        exp_resp(32'hA000_0001);
        tick();
        drive(3'b000, 3'b111, 1'b1, 1'b1, 32'hA000_0002);
        exp_resp(32'hA000_0002);
        tick();
        drive(3'b000, 3'b111, 1'b1, 1'b0, 32'h0);
        chk("t2_drain", 128'(inflight_o), 128'(0));

        // Test 3: OUTSTANDING limit blocks the request
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(3'b111, 3'b111, 1'b1, 1'b0, 32'h0);
            exp_grant((1 + i) % 3);
            tick();
        end
        drive(3'b111, 3'b111, 1'b1, 1'b0, 32'h0);
        chk("t3_full_req", 128'(tcdm_req_o), 128'(0));
        chk("t3_full_gnt", 128'(ch_gnt_o), 128'(0));
        chk("t3_full_add", 128'(tcdm_add_o), 128'(0));
        chk("t3_full_cnt", 128'(inflight_o), 128'(4));
        tick();
        drive(3'b111, 3'b111, 1'b1, 1'b1, 32'hB000_0001);
        exp_resp(32'hB000_0001);
        chk("t3_still_blocked", 128'(tcdm_req_o), 128'(0));
        tick();
        drive(3'b111, 3'b111, 1'b1, 1'b0, 32'h0);
        chk("t3_cnt3", 128'(inflight_o), 128'(3));
        exp_grant(2);
        tick();

        // Test 4: simultaneous handshake and response at inflight 2
        drive(3'b000, 3'b111, 1'b1, 1'b1, 32'hC000_0001);
        exp_resp(32'hC000_0001);
        tick();
        drive(3'b000, 3'b111, 1'b1, 1'b1, 32'hC000_0002);
        exp_resp(32'hC000_0002);
        tick();
        drive(3'b111, 3'b111, 1'b1, 1'b1, 32'hC000_0003);
        chk("t4_cnt2_before", 128'(inflight_o), 128'(2));
        exp_resp(32'hC000_0003);
        exp_grant(0);
        tick();
        drive(3'b000, 3'b111, 1'b1, 1'b0, 32'h0);
        chk("t4_cnt2_after", 128'(inflight_o), 128'(2));
        drive(3'b000, 3'b111, 1'b1, 1'b1, 32'hC000_0004);
        exp_resp(32'hC000_0004);
        tick();
        drive(3'b000, 3'b111, 1'b1, 1'b1, 32'hC000_0005);
        exp_resp(32'hC000_0005);
        tick();
        drive(3'b000, 3'b111, 1'b1, 1'b0, 32'h0);
        chk("t4_drain", 128'(inflight_o), 128'(0));

        // Test 5: ch1 masked off, grants alternate 2,0,2,0
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(3'b111, 3'b101, 1'b1, 1'b0, 32'h0);
            exp_grant((i % 2 == 0) ? 2 : 0);
            tick();
        end
        drive(3'b000, 3'b101, 1'b1, 1'b1, 32'hE000_0001);
        exp_resp(32'hE000_0001);
        tick();
        drive(3'b000, 3'b101, 1'b1, 1'b1, 32'hE000_0002);
        exp_resp(32'hE000_0002);
        tick();
        drive(3'b000, 3'b111, 1'b1, 1'b0, 32'h0);
        chk("t5_cnt2", 128'(inflight_o), 128'(2));

        // Test 6: clear forgets in-flight loads; late responses raise err
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        exp_q.delete();
        drive(3'b000, 3'b111, 1'b1, 1'b0, 32'h0);
        chk("t6_clr_cnt", 128'(inflight_o), 128'(0));
        chk("t6_clr_busy", 128'(busy_o), 128'(0));
        chk("t6_clr_err", 128'(err_o), 128'(0));
        tick();
        drive(3'b000, 3'b111, 1'b1, 1'b1, 32'hF000_0001);
        chk("t6_drop1", 128'(ch_r_valid_o), 128'(0));
        tick();
        drive(3'b000, 3'b111, 1'b1, 1'b1, 32'hF000_0002);
        chk("t6_err1", 128'(err_o), 128'(1));
        chk("t6_drop2", 128'(ch_r_valid_o), 128'(0));
        tick();
        drive(3'b000, 3'b111, 1'b1, 1'b0, 32'h0);
        chk("t6_err_sticky", 128'(err_o), 128'(1));
        chk("t6_cnt0", 128'(inflight_o), 128'(0));
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        drive(3'b001, 3'b111, 1'b1, 1'b0, 32'h0);
        chk("t6_err_cleared", 128'(err_o), 128'(0));
        exp_grant(0);
        tick();

        // Reset mid-operation behaves like clear
        rst_ni = 1'b0;
        drive(3'b111, 3'b111, 1'b1, 1'b0, 32'h1234_5678);
        chk("mrst_req", 128'(tcdm_req_o), 128'(0));
        chk("mrst_gnt", 128'(ch_gnt_o), 128'(0));
        chk("mrst_rdata", 128'(ch_r_data_o), 128'(0));
        tick();
        rst_ni = 1'b1;
        exp_q.delete();
        drive(3'b000, 3'b111, 1'b1, 1'b0, 32'h0);
        chk("mrst_cnt", 128'(inflight_o), 128'(0));
        chk("mrst_busy", 128'(busy_o), 128'(0));
        drive(3'b000, 3'b111, 1'b1, 1'b1, 32'h0);
        chk("mrst_drop", 128'(ch_r_valid_o), 128'(0));
        tick();
        drive(3'b000, 3'b111, 1'b1, 1'b0, 32'h0);
        chk("mrst_err", 128'(err_o), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
